// File: rtl/draw_rect_char_pkg.sv
// ============================================================================
// Module      : draw_rect_char_pkg
// Description : Shared text-grid geometry, pipeline latency and VGA bus type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_rect_char_pkg;

    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int TXT_COLS = 16;
    localparam int TXT_ROWS = 16;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

endpackage

`default_nettype wire

// File: rtl/draw_rect_char_signal_delay.sv
// ============================================================================
// Module      : signal_delay
// Description : Fixed-length register chain delaying a bus by CLK_DEL cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [CLK_DEL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < CLK_DEL; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[CLK_DEL-1];

endmodule

`default_nettype wire

// File: rtl/draw_rect_char.sv
// ============================================================================
// Module      : draw_rect_char
// Description : Overlays a 16x16 character text area on a VGA pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_rect_char
    import draw_rect_char_pkg::*;
#(
    parameter logic [10:0] XPOS  = 11'd100,
    parameter logic [10:0] YPOS  = 11'd50,
    parameter logic [11:0] COLOR = 12'hFFF
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_area_d;
    logic [7:0]  char_xy_d;
    logic [3:0]  char_line_d;

    logic [2:0]  px_col_s1_q;
    logic        in_area_s1_q;
    logic [2:0]  px_col_s2_q;
    logic        in_area_s2_q;

    vga_bus_t    bus_in;
    vga_bus_t    bus_dly;
    logic [$bits(vga_bus_t)-1:0] bus_dly_raw;

    assign dx = hcount_in - XPOS;
    assign dy = vcount_in - YPOS;

    // High offset bits must be zero and the raw count must not sit below the
    // origin, so that wrapped (underflowed) offsets never register a hit.
    assign in_area_d = (dx[10:7] == '0) && (dy[10:8] == '0) &&
                       (hcount_in >= XPOS) && (vcount_in >= YPOS);

    always_comb begin
        char_xy_d   = '0;
        char_line_d = '0;
        if (in_area_d) begin
            char_xy_d   = {dy[7:4], dx[6:3]};
            char_line_d = dy[3:0];
        end
    end

    assign bus_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync: hsync_in, vsync: vsync_in,
                      hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    // The last of the PIPE_LAT stages is the output register below.
    signal_delay #(
        .WIDTH   ($bits(vga_bus_t)),
        .CLK_DEL (PIPE_LAT - 1)
    ) u_timing_delay (
        .clk    (pclk),
        .rst_n  (rst_n),
        .din_i  (bus_in),
        .dout_o (bus_dly_raw)
    );

    assign bus_dly = vga_bus_t'(bus_dly_raw);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy      <= '0;
            char_line    <= '0;
            px_col_s1_q  <= '0;
            in_area_s1_q <= 1'b0;
            px_col_s2_q  <= '0;
            in_area_s2_q <= 1'b0;
            hcount_out   <= '0;
            vcount_out   <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            rgb_out      <= '0;
        end else begin
            char_xy      <= char_xy_d;
            char_line    <= char_line_d;
            px_col_s1_q  <= dx[2:0];
            in_area_s1_q <= in_area_d;
            px_col_s2_q  <= px_col_s1_q;
            in_area_s2_q <= in_area_s1_q;
            hcount_out   <= bus_dly.hcount;
            vcount_out   <= bus_dly.vcount;
            hsync_out    <= bus_dly.hsync;
            vsync_out    <= bus_dly.vsync;
            hblnk_out    <= bus_dly.hblnk;
            vblnk_out    <= bus_dly.vblnk;
            if (bus_dly.hblnk || bus_dly.vblnk) begin
                rgb_out <= '0;
            end else if (in_area_s2_q && char_pixels[3'd7 - px_col_s2_q]) begin
                rgb_out <= COLOR;
            end else begin
                rgb_out <= bus_dly.rgb;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_char.sv
// ============================================================================
// Module      : tb_draw_rect_char
// Description : Self-checking bench for draw_rect_char with a font-ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_rect_char;

    localparam logic [10:0] XP  = 11'd100;
    localparam logic [10:0] YP  = 11'd50;
    localparam logic [11:0] COL = 12'hFFF;

    logic        pclk;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [7:0]  char_pixels;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_rect_char #(.XPOS(XP), .YPOS(YP), .COLOR(COL)) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblnk_in    (hblnk_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .char_pixels (char_pixels),
        .char_xy     (char_xy),
        .char_line   (char_line),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblnk_out   (hblnk_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } smp_t;

    smp_t       hist[$];
    int         cnt;
    int         compared;
    int         mismatched;
    logic [7:0] prev_xy;
    logic [3:0] prev_line;

    // Font ROM contents: cell 0 / line 0 holds only the leftmost pixel.
    function automatic logic [7:0] font(logic [7:0] a, logic [3:0] l);
        if (a == 8'h00 && l == 4'h0) return 8'h80;
        return 8'((int'(a) * 29) ^ (int'(l) * 17) ^ 8'h3C);
    endfunction

    function automatic bit in_area(smp_t s);
        int x = int'(s.h) - int'(XP);
        int y = int'(s.v) - int'(YP);
        return (x >= 0) && (x < 128) && (y >= 0) && (y < 256);
    endfunction

    function automatic logic [7:0] exp_xy(smp_t s);
        int x = int'(s.h) - int'(XP);
        int y = int'(s.v) - int'(YP);
        if (!in_area(s)) return 8'h00;
        return 8'((y / 16) * 16 + (x / 8));
    endfunction

    function automatic logic [3:0] exp_line(smp_t s);
        int y = int'(s.v) - int'(YP);
        if (!in_area(s)) return 4'h0;
        return 4'(y % 16);
    endfunction

    function automatic logic [11:0] exp_rgb(smp_t s);
        logic [7:0] p;
        int x = int'(s.h) - int'(XP);
        if (s.hb || s.vb) return 12'h000;
        if (in_area(s)) begin
            p = font(exp_xy(s), exp_line(s));
            if (p[7 - (x % 8)]) return COL;
        end
        return s.rgb;
    endfunction

    task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        smp_t s;
        smp_t e;
        smp_t f;
        @(posedge pclk);
        s.h = hcount_in;  s.v = vcount_in;
        s.hs = hsync_in;  s.vs = vsync_in;
        s.hb = hblnk_in;  s.vb = vblnk_in;
        s.rgb = rgb_in;
        cnt = rst_n ? cnt + 1 : 0;
        hist.push_front(s);
        if (hist.size() > 4) void'(hist.pop_back());
        #1;
        f = (cnt >= 1) ? hist[0] : '0;
        e = (cnt >= 3) ? hist[2] : '0;
        chk("char_xy",    {4'h0, char_xy},     {4'h0, exp_xy(f)});
        chk("char_line",  {8'h0, char_line},   {8'h0, exp_line(f)});
        chk("hcount_out", {1'b0, hcount_out},  {1'b0, e.h});
        chk("vcount_out", {1'b0, vcount_out},  {1'b0, e.v});
        chk("hsync_out",  {11'h0, hsync_out},  {11'h0, e.hs});
        chk("vsync_out",  {11'h0, vsync_out},  {11'h0, e.vs});
        chk("hblnk_out",  {11'h0, hblnk_out},  {11'h0, e.hb});
        chk("vblnk_out",  {11'h0, vblnk_out},  {11'h0, e.vb});
        chk("rgb_out",    rgb_out,             exp_rgb(e));
        // External ROM registered the address that was present before this edge.
        char_pixels = font(prev_xy, prev_line);
        prev_xy     = char_xy;
        prev_line   = char_line;
    endtask

    task automatic drive(int h, int v, bit hb, bit vb, logic [11:0] rgb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
        rgb_in    = rgb;
    endtask

    initial begin
        int h, v;
        compared = 0; mismatched = 0; cnt = 0;
        prev_xy = '0; prev_line = '0; char_pixels = '0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 12'h000);
        repeat (3) step();
        rst_n = 1'b1;

        drive(100, 50, 0, 0, 12'h123); step();
        chk("lit_xy_origin", {4'h0, char_xy}, 12'h000);
        chk("lit_line_origin", {8'h0, char_line}, 12'h000);
        drive(101, 50, 0, 0, 12'h456); step();
        drive(108, 146, 0, 0, 12'h000); step();
        chk("lit_xy_61", {4'h0, char_xy}, 12'h061);
        chk("lit_line_0", {8'h0, char_line}, 12'h000);
        chk("lit_rgb_fg", rgb_out, 12'hFFF);
        drive(227, 305, 0, 0, 12'h000); step();
        chk("lit_xy_ff", {4'h0, char_xy}, 12'h0FF);
        chk("lit_line_15", {8'h0, char_line}, 12'h00F);
        chk("lit_rgb_bg", rgb_out, 12'h456);
        drive(228, 50, 0, 0, 12'h0F0); step();
        chk("lit_xy_xedge", {4'h0, char_xy}, 12'h000);
        drive(100, 306, 0, 0, 12'h0F0); step();
        chk("lit_xy_yedge", {4'h0, char_xy}, 12'h000);
        drive(100, 50, 1, 0, 12'h0F0); step();
        chk("lit_rgb_xedge", rgb_out, 12'h0F0);
        drive(110, 60, 0, 0, 12'h000); step();
        chk("lit_rgb_yedge", rgb_out, 12'h0F0);
        chk("lit_hblnk_pre", {11'h0, hblnk_out}, 12'h000);
        step();
        chk("lit_rgb_blank", rgb_out, 12'h000);
        chk("lit_hblnk_out", {11'h0, hblnk_out}, 12'h001);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                #1;
                chk("async_rst_xy", {4'h0, char_xy}, 12'h000);
                chk("async_rst_line", {8'h0, char_line}, 12'h000);
                chk("async_rst_rgb", rgb_out, 12'h000);
                chk("async_rst_hcnt", {1'b0, hcount_out}, 12'h000);
                chk("async_rst_vcnt", {1'b0, vcount_out}, 12'h000);
                chk("async_rst_strb", {8'h0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 12'h000);
                step();
                step();
                rst_n = 1'b1;
            end
            h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(90, 240)) : int'($urandom_range(0, 2047));
            v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(40, 320)) : int'($urandom_range(0, 2047));
            drive(h, v, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 12'($urandom));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
